// File: rtl/data_mem_controller.sv
// MEM-stage data-memory controller: load/store req/ack sequencing, big-endian lane steering,
// load extension, alignment check and bus timeout. Stalls MEM from request until the ack or timeout.
module data_mem_controller #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_Size,
  input  logic        MEM_Unsigned,
  input  logic [31:0] MEM_Address,
  input  logic [31:0] MEM_WriteData,
  input  logic        M_Stall,
  output logic        M_Stall_Controller,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_AddrErr,
  output logic        MEM_BusErr,
  output logic        DataMem_Req,
  output logic [29:0] DataMem_Addr,
  output logic [3:0]  DataMem_BE,
  output logic [31:0] DataMem_WData,
  input  logic        DataMem_Ack,
  input  logic [31:0] DataMem_RData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      rdata_q;
  logic             bus_err_q;
  logic             load_q;
  logic             uns_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;

  logic        access, aligned, valid;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign access = MEM_MemRead | MEM_MemWrite;

  always_comb begin
    aligned = 1'b1;
    case (MEM_Size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~MEM_Address[0];
      default: aligned = (MEM_Address[1:0] == 2'b00);
    endcase
  end

  assign valid              = access & aligned;
  assign MEM_AddrErr        = access & ~aligned;
  assign M_Stall_Controller = ((state == IDLE) & valid) | (state == REQ);
  assign MEM_ReadData       = rdata_q;
  assign MEM_BusErr         = bus_err_q;

  // BE[3] is the byte at offset 0 (big-endian); loads enable no lanes.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = MEM_WriteData;
    case (MEM_Size)
      2'b00: begin
        be_nxt    = 4'b1000 >> MEM_Address[1:0];
        wdata_nxt = {4{MEM_WriteData[7:0]}};
      end
      2'b01: begin
        be_nxt    = MEM_Address[1] ? 4'b0011 : 4'b1100;
        wdata_nxt = {2{MEM_WriteData[15:0]}};
      end
      default: be_nxt = 4'b1111;
    endcase
    if (!MEM_MemWrite) be_nxt = 4'b0000;
  end

  always_comb begin
    ld_byte = DataMem_RData[31:24];
    case (off_q)
      2'd0: ld_byte = DataMem_RData[31:24];
      2'd1: ld_byte = DataMem_RData[23:16];
      2'd2: ld_byte = DataMem_RData[15:8];
      2'd3: ld_byte = DataMem_RData[7:0];
      default: ld_byte = DataMem_RData[31:24];
    endcase
    ld_half = off_q[1] ? DataMem_RData[15:0] : DataMem_RData[31:16];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = DataMem_RData;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      rdata_q       <= '0;
      bus_err_q     <= 1'b0;
      load_q        <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      DataMem_Req   <= 1'b0;
      DataMem_Addr  <= '0;
      DataMem_BE    <= '0;
      DataMem_WData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            DataMem_Addr  <= MEM_Address[31:2];
            DataMem_BE    <= be_nxt;
            DataMem_WData <= wdata_nxt;
            DataMem_Req   <= 1'b1;
            count         <= '0;
            load_q        <= MEM_MemRead;
            uns_q         <= MEM_Unsigned;
            size_q        <= MEM_Size;
            off_q         <= MEM_Address[1:0];
            state         <= REQ;
          end
        end
        REQ: begin
          count <= count + 1'b1;
          if (DataMem_Ack) begin
            if (load_q) rdata_q <= ld_ext;
            DataMem_Req <= 1'b0;
            bus_err_q   <= 1'b0;
            state       <= DONE;
          end else if (count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            DataMem_Req <= 1'b0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Another stall source holds MEM: wait here without reissuing.
          if (!M_Stall) begin
            bus_err_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: table-driven accesses with a scoreboard queue,
// plus hand sequences for DONE hold, bus timeout and asynchronous reset.
module tb_data_mem_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        mem_rd, mem_wr, mem_uns, m_stall;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall_ctrl, addr_err, bus_err, req, ack;
  logic [31:0] read_data, wdata, rdata;
  logic [29:0] addr;
  logic [3:0]  be;

  int tests  = 0;
  int failed = 0;

  data_mem_controller dut (
    .clock(clock), .reset_n(reset_n),
    .MEM_MemRead(mem_rd), .MEM_MemWrite(mem_wr), .MEM_Size(mem_size),
    .MEM_Unsigned(mem_uns), .MEM_Address(mem_addr), .MEM_WriteData(mem_wdata),
    .M_Stall(m_stall), .M_Stall_Controller(stall_ctrl), .MEM_ReadData(read_data),
    .MEM_AddrErr(addr_err), .MEM_BusErr(bus_err), .DataMem_Req(req),
    .DataMem_Addr(addr), .DataMem_BE(be), .DataMem_WData(wdata),
    .DataMem_Ack(ack), .DataMem_RData(rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic        exp_aerr;
    int          exp_stall;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_rd = 0; mem_wr = 0; mem_size = 2'b10; mem_uns = 0;
    mem_addr = 0; mem_wdata = 0; ack = 0; rdata = 0;
  endtask

  task automatic drive(input vec_t v);
    mem_rd = v.rd; mem_wr = v.wr; mem_size = v.size; mem_uns = v.uns;
    mem_addr = v.addr; mem_wdata = v.wdata;
  endtask

  // Called at a negedge; acts as the memory, acking in REQ cycle ack_dly.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int stall_n, req_n;
    bit done;
    logic [3:0]  be_s;
    logic [29:0] a_s;
    logic [31:0] wd_s;
    be_s = 0; a_s = 0; wd_s = 0;
    drive(v);
    sb.push_back(v);
    #1;
    chk("addr_err", addr_err, v.exp_aerr);
    stall_n = 0; req_n = 0; done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (!stall_ctrl) done = 1;
      else begin
        stall_n++;
        if (req) begin
          req_n++;
          be_s = be; a_s = addr; wd_s = wdata;
          if (req_n == v.ack_dly) begin ack = 1; rdata = v.rdata; end
        end
        @(posedge clock); @(negedge clock);
        ack = 0; rdata = 0;
      end
    end
    if (!done) chk("access_done", 0, 1);
    e = sb.pop_front();
    chk("stall_cycles", stall_n, e.exp_stall);
    chk("req_cycles", req_n, e.exp_aerr ? 0 : e.ack_dly);
    if (!e.exp_aerr) begin
      chk("mem_addr", {2'b0, a_s}, {2'b0, e.addr[31:2]});
      chk("be", {28'b0, be_s}, {28'b0, e.exp_be});
      chk("req_low_done", {31'b0, req}, 0);
      chk("bus_err_ok", {31'b0, bus_err}, 0);
      if (e.wr) chk("wdata", wd_s, e.exp_wd);
      if (e.rd) chk("read_data", read_data, e.exp_rd);
    end
    idle_inputs();
    @(posedge clock); @(negedge clock);
    if (e.exp_aerr) chk("no_req_misaligned", {31'b0, req}, 0);
  endtask

  initial begin
    int stall_n, req_n;
    logic [31:0] held;
    //           rd wr size  uns addr          wdata         rdata         dly exp_rd        be       exp_wd        aerr stall
    vecs[0]  = '{1, 0, 2'b10, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 4'b0000, 32'h0,        0, 4};
    vecs[1]  = '{1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,        32'h0000_00F0, 1, 32'hFFFF_FFF0, 4'b0000, 32'h0,        0, 2};
    vecs[2]  = '{1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h0000_00F0, 1, 32'h0000_00F0, 4'b0000, 32'h0,        0, 2};
    vecs[3]  = '{0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 32'h0,         4'b0011, 32'hABCD_ABCD, 0, 2};
    vecs[4]  = '{1, 0, 2'b10, 0, 32'h0000_0101, 32'h0,        32'h0,         1, 32'h0,         4'b0000, 32'h0,        1, 0};
    vecs[5]  = '{0, 1, 2'b00, 0, 32'h0000_0001, 32'h0000_0055, 32'h0,        2, 32'h0,         4'b0100, 32'h5555_5555, 0, 3};
    vecs[6]  = '{1, 0, 2'b01, 0, 32'h0000_0000, 32'h0,        32'h8001_7FFF, 1, 32'hFFFF_8001, 4'b0000, 32'h0,        0, 2};
    vecs[7]  = '{1, 0, 2'b01, 1, 32'h0000_0002, 32'h0,        32'h8001_8002, 1, 32'h0000_8002, 4'b0000, 32'h0,        0, 2};
    vecs[8]  = '{0, 1, 2'b10, 0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,        1, 32'h0,         4'b1111, 32'hCAFE_F00D, 0, 2};
    vecs[9]  = '{1, 0, 2'b01, 0, 32'h0000_0003, 32'h0,        32'h0,         1, 32'h0,         4'b0000, 32'h0,        1, 0};
    vecs[10] = '{1, 0, 2'b00, 0, 32'h0000_0000, 32'h0,        32'h7F00_0000, 2, 32'h0000_007F, 4'b0000, 32'h0,        0, 3};
    vecs[11] = '{1, 0, 2'b11, 0, 32'h0000_0010, 32'h0,        32'h1234_5678, 1, 32'h1234_5678, 4'b0000, 32'h0,        0, 2};

    idle_inputs();
    m_stall = 0;
    reset_n = 0;
    #12;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_be", {28'b0, be}, 0);
    chk("rst_addr", {2'b0, addr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_bus_err", {31'b0, bus_err}, 0);
    chk("rst_stall", {31'b0, stall_ctrl}, 0);
    chk("rst_addr_err", {31'b0, addr_err}, 0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    foreach (vecs[i]) run_vec(vecs[i]);

    // DONE held by an external stall: one request only, data stable
    mem_rd = 1; mem_size = 2'b10; mem_addr = 32'h20; m_stall = 1;
    req_n = 0;
    @(posedge clock); @(negedge clock);
    if (req) begin req_n++; ack = 1; rdata = 32'hA5A5_1234; end
    @(posedge clock); @(negedge clock);
    ack = 0; rdata = 0;
    for (int c = 0; c < 3; c++) begin
      if (req) req_n++;
      chk("hold_stall_ctrl", {31'b0, stall_ctrl}, 0);
      chk("hold_read_data", read_data, 32'hA5A5_1234);
      @(posedge clock); @(negedge clock);
    end
    idle_inputs();
    m_stall = 0;
    @(posedge clock); @(negedge clock);
    if (req) req_n++;
    chk("hold_req_count", req_n, 1);

    // Bus timeout: no ack for TIMEOUT_CYCLES REQ cycles
    mem_rd = 1; mem_size = 2'b10; mem_addr = 32'h40;
    stall_n = 0; req_n = 0;
    #1;
    for (int c = 0; c < 400 && stall_ctrl; c++) begin
      stall_n++;
      if (req) req_n++;
      @(posedge clock); @(negedge clock);
    end
    chk("to_req_cycles", req_n, 256);
    chk("to_stall_cycles", stall_n, 257);
    chk("to_bus_err", {31'b0, bus_err}, 1);
    chk("to_req_low", {31'b0, req}, 0);
    chk("to_read_data", read_data, 0);
    // stray ack outside REQ, with DONE held
    m_stall = 1; ack = 1; rdata = 32'hFFFF_FFFF;
    @(posedge clock); @(negedge clock);
    ack = 0; rdata = 0;
    chk("stray_ack_req", {31'b0, req}, 0);
    chk("stray_ack_bus_err", {31'b0, bus_err}, 1);
    chk("stray_ack_read_data", read_data, 0);
    idle_inputs();
    m_stall = 0;
    @(posedge clock); @(negedge clock);
    chk("to_bus_err_clear", {31'b0, bus_err}, 0);

    // Async reset in the middle of a request
    mem_rd = 1; mem_size = 2'b10; mem_addr = 32'h80;
    @(posedge clock); @(negedge clock);
    chk("rst_mid_req_high", {31'b0, req}, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_req_low", {31'b0, req}, 0);
    idle_inputs();
    @(negedge clock);
    reset_n = 1;
    @(posedge clock); @(negedge clock);
    chk("rst_after_req", {31'b0, req}, 0);
    chk("rst_after_stall", {31'b0, stall_ctrl}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
